// File: rtl/textload_feeder.sv
// textload_feeder: buffers an ioctl text download and replays it as paced rx characters.
// Optional TEXTLOAD_CRLF_XLAT_EN: drop LF after CR and present a lone LF as CR.
module textload_feeder #(
    parameter int ADDR_W   = 13,
    parameter int CHAR_GAP = 50000,
    parameter int LINE_GAP = 5000000
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [ADDR_W-1:0] ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic [7:0]        rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              busy
);
    localparam int GMAX = CHAR_GAP > LINE_GAP ? CHAR_GAP : LINE_GAP;
    localparam int CW = GMAX > 0 ? $clog2(GMAX + 1) : 1;
    localparam logic [CW-1:0] CHAR_G = CW'(CHAR_GAP);
    localparam logic [CW-1:0] LINE_G = CW'(LINE_GAP);
    localparam logic [CW-1:0] G_ONE = CW'(1);
    localparam logic [ADDR_W:0] ONE = 1;

    typedef enum logic [2:0] {IDLE, LOAD, FETCH, PRESENT, GAP} state_t;

    state_t          state_q;
    logic [7:0]      mem [2**ADDR_W];
    logic [7:0]      rd_byte_q, rx_data_q, fetched;
    logic [ADDR_W:0] len_q, rd_ptr_q, wr_end_d;
    logic [CW-1:0]   gap_q;
    logic            dl_q, fetch_ph_q, rx_valid_q, busy_q;
    logic            dl_rise, dl_fall, lf_skip;

    assign dl_rise  = ioctl_download & ~dl_q;
    assign dl_fall  = ~ioctl_download & dl_q;
    assign wr_end_d = {1'b0, ioctl_addr} + ONE;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;

`ifdef TEXTLOAD_CRLF_XLAT_EN
    logic prev_cr_q;

    assign lf_skip = rd_byte_q == 8'h0A && prev_cr_q;
    assign fetched = rd_byte_q == 8'h0A ? 8'h0D : rd_byte_q;

    // Tracks the raw byte last presented; rd_byte_q still holds it during PRESENT
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset)
            prev_cr_q <= 1'b0;
        else if (dl_rise)
            prev_cr_q <= 1'b0;
        else if (state_q == PRESENT && rx_ready)
            prev_cr_q <= rd_byte_q == 8'h0D;
        else if (state_q == FETCH && fetch_ph_q && lf_skip)
            prev_cr_q <= 1'b0;
    end
`else
    assign lf_skip = 1'b0;
    assign fetched = rd_byte_q;
`endif

    always_ff @(posedge clk) begin
        if (state_q == LOAD && ioctl_wr)
            mem[ioctl_addr] <= ioctl_dout;
        if (state_q == FETCH)
            rd_byte_q <= mem[rd_ptr_q[ADDR_W-1:0]];
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= IDLE;
            dl_q       <= 1'b0;
            len_q      <= '0;
            rd_ptr_q   <= '0;
            gap_q      <= '0;
            fetch_ph_q <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            dl_q <= ioctl_download;
            if (dl_rise) begin
                state_q    <= LOAD;
                len_q      <= '0;
                rx_valid_q <= 1'b0;
                busy_q     <= 1'b0;
            end else begin
                case (state_q)
                    LOAD: begin
                        if (ioctl_wr) begin
                            busy_q <= 1'b1;
                            if (wr_end_d > len_q)
                                len_q <= wr_end_d;
                        end
                        if (dl_fall) begin
                            if (len_q == '0) begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end else begin
                                rd_ptr_q   <= '0;
                                fetch_ph_q <= 1'b0;
                                state_q    <= FETCH;
                            end
                        end
                    end
                    // Phase 0 issues the read, phase 1 sees the RAM output
                    FETCH: begin
                        fetch_ph_q <= ~fetch_ph_q;
                        if (fetch_ph_q) begin
                            if (rd_ptr_q == len_q) begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end else if (lf_skip) begin
                                rd_ptr_q <= rd_ptr_q + ONE;
                            end else begin
                                rx_data_q  <= fetched;
                                rx_valid_q <= 1'b1;
                                state_q    <= PRESENT;
                            end
                        end
                    end
                    PRESENT: begin
                        if (rx_ready) begin
                            rx_valid_q <= 1'b0;
                            rd_ptr_q   <= rd_ptr_q + ONE;
                            gap_q      <= rx_data_q == 8'h0D ? LINE_G : CHAR_G;
                            state_q    <= GAP;
                        end
                    end
                    GAP: begin
                        if (gap_q == '0) begin
                            fetch_ph_q <= 1'b0;
                            state_q    <= FETCH;
                        end else begin
                            gap_q <= gap_q - G_ONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: doc/textload_feeder.md
# textload_feeder

Buffers an ASCII text file downloaded over the HPS ioctl channel and replays it, byte by byte, as paced receive characters into the UK101 machine's serial/keyboard input path. It sits directly upstream of the `uk101` core, between the `hps_io` download port and the core's text-input data port. Pacing gives the 6502 monitor/BASIC time to consume each character and tokenise each line.

## Interface
Parameters:
- `ADDR_W`, default 13: buffer address width; depth = 2^ADDR_W bytes (8 KiB).
- `CHAR_GAP`, default 50000: idle clocks after each accepted byte (1 ms at 50 MHz).
- `LINE_GAP`, default 5000000: idle clocks after an accepted CR (0x0D), replacing `CHAR_GAP` (100 ms at 50 MHz).

Ports:
- `clk`  in  1: system clock (`clk_sys`, 50 MHz).
- `n_reset`  in  1: reset; asynchronous and active-low.
- `ioctl_download`  in  1: download in progress; already qualified by a non-zero `ioctl_index` upstream.
- `ioctl_wr`  in  1: write strobe, one clock per byte.
- `ioctl_addr`  in  ADDR_W: byte address.
- `ioctl_dout`  in  8: byte data.
- `rx_data`  out  8: character presented to the core.
- `rx_valid`  out  1: `rx_data` is valid.
- `rx_ready`  in  1: core accepts the character.
- `busy`  out  1: high from the first write until the last byte is accepted.

## Operation
The block is a state machine with five states: IDLE, LOAD, FETCH, PRESENT, GAP.

- **IDLE.** On `ioctl_download` rise, clear `len`, go to LOAD.
- **LOAD.**
  - Each `ioctl_wr` writes `ioctl_dout` to the buffer at `ioctl_addr`.
  - `len` (ADDR_W+1 bits) becomes max(`len`, `ioctl_addr`+1).
  - On `ioctl_download` fall: if `len`==0, go to IDLE; otherwise set `rd_ptr`=0 and go to FETCH.
- **FETCH.**
  - Issue a synchronous read at `rd_ptr`. The RAM has 1-clock read latency, so FETCH lasts 2 clocks; then go to PRESENT.
  - If `rd_ptr`==`len`, go to IDLE instead.
- **PRESENT.**
  - `rx_valid`=1. `rx_data` is held stable until `rx_valid && rx_ready`.
  - On acceptance: `rd_ptr`++; load the gap counter with `LINE_GAP` if `rx_data`==0x0D, else `CHAR_GAP`; go to GAP.
- **GAP.** Decrement the counter; at 0 go to FETCH.
  - Counter width is clog2 of max(`CHAR_GAP`, `LINE_GAP`)+1.
  - A gap value of 0 means exactly one GAP clock.
- **Abort.** A rise of `ioctl_download` in any state aborts playback: drop `rx_valid`, clear `len`, go to LOAD. This takes priority over all other transitions in that clock.
- **Truncation.** Bytes whose address falls outside the buffer are unrepresentable because `ioctl_addr` is ADDR_W wide. The top level truncates the wider ioctl address, so files larger than 2^ADDR_W bytes alias. Aliasing is documented, not detected.
- **Write-hazard rule.** Writes occur only in LOAD and reads only in FETCH, so there is no read/write collision.

## Timing
- Reset values: `rx_valid`=0, `rx_data`=0x00, `busy`=0, state IDLE, `len`=0, `rd_ptr`=0.
- Buffer contents are not reset.
- Latency from `ioctl_download` fall to first `rx_valid`: 3 clocks (1 clock LOAD exit + 2 clocks FETCH).
- Per-byte period with `rx_ready` tied high: 1 (PRESENT) + gap + 1 (GAP exit) + 2 (FETCH) clocks.
- `busy` rises in the clock after the first `ioctl_wr`. It falls in the clock FETCH detects `rd_ptr`==`len`, or on entry to IDLE from LOAD.
- Edge detection on `ioctl_download` uses one registered copy of the signal. Edges are therefore acted on 1 clock after they appear on the input.

## Configuration
- Macro: `TEXTLOAD_CRLF_XLAT_EN`.
- **Defined.** Line endings are translated in FETCH:
  - A 0x0A following a 0x0D is skipped: `rd_ptr`++, re-fetch, costing 2 clocks and no gap.
  - A 0x0A not preceded by 0x0D is presented as 0x0D, and `LINE_GAP` applies.
  - A 1-bit "previous byte was CR" flag is cleared on LOAD entry.
- **Not defined.** All bytes are presented verbatim. 0x0A gets `CHAR_GAP`.

## Test plan
Bench parameters: CHAR_GAP=4, LINE_GAP=20, ADDR_W=4.

1. **Basic playback.** Download "AB\r" at addresses 0..2, `rx_ready`=1.
   - Expect 0x41, 0x42, 0x0D each valid for 1 clock.
   - Gaps between the 0x41 and 0x42 acceptances: exactly 8 clocks.
   - `busy` falls 23 clocks after the 0x0D acceptance (LINE_GAP plus exit).
2. **Backpressure.** Hold `rx_ready`=0 for 10 clocks on the first byte.
   - `rx_valid` and `rx_data`=0x41 stay stable for all 10 clocks.
   - Byte order is unchanged.
3. **Line-ending translation.** Download "1\r\n2\n".
   - With the macro: outputs 0x31, 0x0D, 0x32, 0x0D.
   - Without the macro: outputs 0x31, 0x0D, 0x0A, 0x32, 0x0A.
4. **Abort and empty download.**
   - Start a second download mid-GAP: `rx_valid` stays 0 and the new file plays from address 0.
   - A download with zero writes returns to IDLE with `busy`=0 and no `rx_valid`.
5. **Reset mid-operation.** Assert `n_reset`=0 asynchronously during PRESENT.
   - `rx_valid`=0 and `busy`=0 immediately, without waiting for a clock edge.
   - After release, no output appears until a new download.
6. **Sparse writes.** Write only address 5 (0x58).
   - `len`=6; six bytes are presented (addresses 0..4 hold stale or initial RAM data).
   - The last byte presented is 0x58.
